// File: rtl/sync_pattern_gen_pkg.sv
// sync_pattern_gen_pkg: pattern encodings, LFSR seed/step and default rate constants
package sync_pattern_gen_pkg;
    typedef enum logic [1:0] {
        PAT_SQUARE = 2'd0,
        PAT_RAMP   = 2'd1,
        PAT_PRBS   = 2'd2,
        PAT_CONST  = 2'd3
    } pat_e;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam int DEF_DIV       = 500;
    localparam int DEF_FRAME_LEN = 512;
    localparam int DEF_SYNC_LEN  = 9;
    localparam int DEF_NFRAME    = 105;
    localparam int DEF_NBLANK    = 5;
    localparam int DEF_NCHN      = 4;
    localparam int DEF_DATA_NBIT = 16;
    // x^16+x^14+x^13+x^11+1, Fibonacci, shifting left with feedback into bit 0
    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    endfunction
endpackage

// File: rtl/sync_pattern_gen_if.sv
// sync_pattern_gen_if: control inputs and generated outputs of the pattern generator
interface sync_pattern_gen_if
    import sync_pattern_gen_pkg::*;
#(
    parameter int NCHN      = DEF_NCHN,
    parameter int DATA_NBIT = DEF_DATA_NBIT,
    parameter int NFRAME    = DEF_NFRAME
);
    logic                        en;
    logic [1:0]                  mode;
    logic [DATA_NBIT-1:0]        const_val;
    logic                        spclk;
    logic                        sync;
    logic [NCHN-1:0]             data;
    logic [NCHN*DATA_NBIT-1:0]   smp_word;
    logic                        smp_vd;
    logic                        frame_start;
    logic [$clog2(NFRAME)-1:0]   frm_cnt;
    modport master (
        input  en, mode, const_val,
        output spclk, sync, data, smp_word, smp_vd, frame_start, frm_cnt
    );
    modport slave (
        output en, mode, const_val,
        input  spclk, sync, data, smp_word, smp_vd, frame_start, frm_cnt
    );
endinterface

// File: rtl/sync_timebase.sv
// sync_timebase: div/sample/frame counters, enable edge detect and registered timing strobes
module sync_timebase
    import sync_pattern_gen_pkg::*;
#(
    parameter int DIV       = DEF_DIV,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int SYNC_LEN  = DEF_SYNC_LEN,
    parameter int NFRAME    = DEF_NFRAME,
    parameter int NBLANK    = DEF_NBLANK,
    localparam int DW = $clog2(DIV),
    localparam int SW = $clog2(FRAME_LEN),
    localparam int FW = $clog2(NFRAME)
) (
    input  logic          mclk,
    input  logic          rst,
    input  logic          en,
    output logic          start,
    output logic          tick,
    output logic          frame_wrap,
    output logic          load,
    output logic [SW-1:0] sp_cnt,
    output logic          spclk,
    output logic          sync,
    output logic          frame_start,
    output logic          smp_vd,
    output logic [FW-1:0] frm_cnt
);
    logic [DW-1:0] div_q, div_d;
    logic [SW-1:0] sp_q, sp_d;
    logic [FW-1:0] frm_q, frm_d, frm_out_q, frm_out_d;
    logic          en_q;
    logic          spclk_q, spclk_d, sync_q, sync_d;
    logic          frame_start_q, frame_start_d, smp_vd_q, smp_vd_d;
    always_comb begin
        start         = en && !en_q;
        tick          = en && div_q == DW'(DIV - 1);
        frame_wrap    = tick && sp_q == SW'(FRAME_LEN - 1);
        load          = en && div_q == '0;
        div_d         = (!en || tick) ? '0 : div_q + 1'b1;
        sp_d          = (!en || frame_wrap) ? '0 : tick ? sp_q + 1'b1 : sp_q;
        frm_d         = !en ? '0 : !frame_wrap ? frm_q : frm_q == FW'(NFRAME - 1) ? '0 : frm_q + 1'b1;
        spclk_d       = en && div_q < DW'(DIV / 2);
        sync_d        = en && sp_q < SW'(SYNC_LEN) && frm_q < FW'(NFRAME - NBLANK);
        frame_start_d = load && sp_q == '0;
        smp_vd_d      = load;
        frm_out_d     = en ? frm_q : '0;
    end
    always_ff @(posedge mclk) begin
        if (rst) begin
            div_q         <= '0;
            sp_q          <= '0;
            frm_q         <= '0;
            en_q          <= 1'b0;
            spclk_q       <= 1'b0;
            sync_q        <= 1'b0;
            frame_start_q <= 1'b0;
            smp_vd_q      <= 1'b0;
            frm_out_q     <= '0;
        end else begin
            div_q         <= div_d;
            sp_q          <= sp_d;
            frm_q         <= frm_d;
            en_q          <= en;
            spclk_q       <= spclk_d;
            sync_q        <= sync_d;
            frame_start_q <= frame_start_d;
            smp_vd_q      <= smp_vd_d;
            frm_out_q     <= frm_out_d;
        end
    end
    assign sp_cnt      = sp_q;
    assign spclk       = spclk_q;
    assign sync        = sync_q;
    assign frame_start = frame_start_q;
    assign smp_vd      = smp_vd_q;
    assign frm_cnt     = frm_out_q;
endmodule

// File: rtl/sync_pattern_gen.sv
// sync_pattern_gen: sample clock, frame sync and per-channel test patterns for the ADC path
module sync_pattern_gen
    import sync_pattern_gen_pkg::*;
#(
    parameter int DIV       = DEF_DIV,
    parameter int FRAME_LEN = DEF_FRAME_LEN,
    parameter int SYNC_LEN  = DEF_SYNC_LEN,
    parameter int NFRAME    = DEF_NFRAME,
    parameter int NBLANK    = DEF_NBLANK,
    parameter int NCHN      = DEF_NCHN,
    parameter int DATA_NBIT = DEF_DATA_NBIT
) (
    input logic               mclk,
    input logic               rst,
    sync_pattern_gen_if.master bus
);
    localparam int SW = $clog2(FRAME_LEN);
    logic                      start, tick, frame_wrap, load;
    logic [SW-1:0]             sp_cnt;
    logic [DATA_NBIT-1:0]      ramp_q, ramp_d;
    logic [15:0]               lfsr_q, lfsr_d;
    pat_e                      mode_q, mode_d, mode_eff;
    logic [NCHN*DATA_NBIT-1:0] word_q, word_d, pat;
    logic [2*DATA_NBIT-1:0]    rot;
    sync_timebase #(
        .DIV(DIV), .FRAME_LEN(FRAME_LEN), .SYNC_LEN(SYNC_LEN), .NFRAME(NFRAME), .NBLANK(NBLANK)
    ) u_timebase (
        .mclk(mclk), .rst(rst), .en(bus.en),
        .start(start), .tick(tick), .frame_wrap(frame_wrap), .load(load), .sp_cnt(sp_cnt),
        .spclk(bus.spclk), .sync(bus.sync), .frame_start(bus.frame_start),
        .smp_vd(bus.smp_vd), .frm_cnt(bus.frm_cnt)
    );
    // The word loaded on the start cycle must already use the freshly requested mode.
    always_comb begin
        mode_eff = start ? pat_e'(bus.mode) : mode_q;
        mode_d   = (start || frame_wrap) ? pat_e'(bus.mode) : mode_q;
        ramp_d   = tick ? ramp_q + 1'b1 : ramp_q;
        lfsr_d   = tick ? lfsr_next(lfsr_q) : lfsr_q;
        pat      = '0;
        rot      = '0;
        for (int k = 0; k < NCHN; k++) begin
            rot = {2{DATA_NBIT'(lfsr_q)}} << ((4 * k) % DATA_NBIT);
            pat[k*DATA_NBIT +: DATA_NBIT] =
                mode_eff == PAT_SQUARE ? {DATA_NBIT{sp_cnt < SW'(FRAME_LEN / 2)}} :
                mode_eff == PAT_RAMP   ? ramp_q + DATA_NBIT'(k) :
                mode_eff == PAT_PRBS   ? rot[2*DATA_NBIT-1 -: DATA_NBIT] :
                                         bus.const_val;
        end
        word_d = !bus.en ? '0 : load ? pat : word_q;
    end
    always_ff @(posedge mclk) begin
        if (rst) begin
            ramp_q <= '0;
            lfsr_q <= LFSR_SEED;
            mode_q <= PAT_SQUARE;
            word_q <= '0;
        end else begin
            ramp_q <= ramp_d;
            lfsr_q <= lfsr_d;
            mode_q <= mode_d;
            word_q <= word_d;
        end
    end
    assign bus.smp_word = word_q;
    for (genvar g = 0; g < NCHN; g++) begin : g_data
        assign bus.data[g] = word_q[g*DATA_NBIT + DATA_NBIT - 1];
    end
endmodule

// File: tb/tb_sync_pattern_gen.sv
// tb_sync_pattern_gen: table-driven timing checks plus a strobe scoreboard for sync_pattern_gen
module tb_sync_pattern_gen;
    localparam int DIV = 8, FL = 16, SL = 3, NF = 5, NB = 2, NCH = 4, W = 16, W8 = 8;
    logic mclk = 1'b0;
    logic rst;
    always #5 mclk = ~mclk;
    sync_pattern_gen_if #(.NCHN(NCH), .DATA_NBIT(W),  .NFRAME(NF)) sp();
    sync_pattern_gen_if #(.NCHN(NCH), .DATA_NBIT(W8), .NFRAME(NF)) sw();
    sync_pattern_gen #(
        .DIV(DIV), .FRAME_LEN(FL), .SYNC_LEN(SL), .NFRAME(NF), .NBLANK(NB), .NCHN(NCH), .DATA_NBIT(W)
    ) dut (.mclk(mclk), .rst(rst), .bus(sp));
    sync_pattern_gen #(
        .DIV(4), .FRAME_LEN(FL), .SYNC_LEN(SL), .NFRAME(NF), .NBLANK(NB), .NCHN(NCH), .DATA_NBIT(W8)
    ) dut8 (.mclk(mclk), .rst(rst), .bus(sw));
    typedef struct {
        int   c;
        logic spclk, sync, fs, vd;
        int   frm;
    } tvec_t;
    tvec_t tab[13];
    logic [NCH*W-1:0]  q_main[$];
    logic [NCH*W8-1:0] q_w[$];
    int checks = 0, errors = 0, c = 0;
    bit tim_on = 1'b0;
    logic [15:0] ramp_m = 16'd0;
    logic [15:0] lfsr_m = 16'hACE1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [15:0] ref_step(input logic [15:0] s);
        return {s[14:0], ^(s & 16'hB400)};
    endfunction

    function automatic logic [15:0] rotl16(input logic [15:0] v, input int n);
        return (v << n) | (v >> (16 - n));
    endfunction

    function automatic logic [3:0] msb16(input logic [NCH*W-1:0] e);
        for (int k = 0; k < NCH; k++) msb16[k] = e[k*W + W - 1];
    endfunction

    function automatic logic [3:0] msb8(input logic [NCH*W8-1:0] e);
        for (int k = 0; k < NCH; k++) msb8[k] = e[k*W8 + W8 - 1];
    endfunction

    task automatic step();
        int s, dv, sm, fr;
        logic [NCH*W-1:0]  e;
        logic [NCH*W8-1:0] e8;
        @(negedge mclk);
        c++;
        if (tim_on) begin
            s  = c - 1;
            dv = s % DIV;
            sm = (s / DIV) % FL;
            fr = (s / (DIV * FL)) % NF;
            chk($sformatf("timing c=%0d", c),
                {sp.spclk, sp.sync, sp.frame_start, sp.smp_vd, sp.frm_cnt},
                {dv < DIV / 2, sm < SL && fr < NF - NB, dv == 0 && sm == 0, dv == 0, 3'(fr)});
        end
        if (sp.smp_vd) begin
            if (q_main.size() == 0) chk("main_extra_strobe", 64'(sp.smp_vd), 64'd0);
            else begin
                e = q_main.pop_front();
                chk("main_word", sp.smp_word, e);
                chk("main_data", 64'(sp.data), 64'(msb16(e)));
            end
        end
        if (sw.smp_vd) begin
            if (q_w.size() == 0) chk("w8_extra_strobe", 64'(sw.smp_vd), 64'd0);
            else begin
                e8 = q_w.pop_front();
                chk("w8_word", 64'(sw.smp_word), 64'(e8));
                chk("w8_data", 64'(sw.data), 64'(msb8(e8)));
            end
        end
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_ctl"}, {sp.spclk, sp.sync, sp.data, sp.smp_vd, sp.frame_start, sp.frm_cnt}, 64'd0);
        chk({name, "_word"}, sp.smp_word, 64'd0);
    endtask

    initial begin
        logic [NCH*W-1:0]  e;
        logic [NCH*W8-1:0] e8;
        tab[0]  = '{1,   1'b1, 1'b1, 1'b1, 1'b1, 0};
        tab[1]  = '{2,   1'b1, 1'b1, 1'b0, 1'b0, 0};
        tab[2]  = '{4,   1'b1, 1'b1, 1'b0, 1'b0, 0};
        tab[3]  = '{5,   1'b0, 1'b1, 1'b0, 1'b0, 0};
        tab[4]  = '{8,   1'b0, 1'b1, 1'b0, 1'b0, 0};
        tab[5]  = '{9,   1'b1, 1'b1, 1'b0, 1'b1, 0};
        tab[6]  = '{24,  1'b0, 1'b1, 1'b0, 1'b0, 0};
        tab[7]  = '{25,  1'b1, 1'b0, 1'b0, 1'b1, 0};
        tab[8]  = '{129, 1'b1, 1'b1, 1'b1, 1'b1, 1};
        tab[9]  = '{257, 1'b1, 1'b1, 1'b1, 1'b1, 2};
        tab[10] = '{385, 1'b1, 1'b0, 1'b1, 1'b1, 3};
        tab[11] = '{640, 1'b0, 1'b0, 1'b0, 1'b0, 4};
        tab[12] = '{641, 1'b1, 1'b1, 1'b1, 1'b1, 0};
        rst = 1'b1;
        sp.en = 1'b0; sp.mode = 2'd0; sp.const_val = '0;
        sw.en = 1'b0; sw.mode = 2'd0; sw.const_val = '0;
        repeat (3) step();
        chk_idle("reset");
        rst = 1'b0;
        step();
        chk_idle("idle_after_reset");
        // PRBS from the reset seed
        sp.mode = 2'd2;
        for (int j = 0; j < 4; j++) begin
            for (int k = 0; k < NCH; k++) e[k*W +: W] = rotl16(lfsr_m, 4 * k);
            q_main.push_back(e);
            lfsr_m = ref_step(lfsr_m);
        end
        c = 0; tim_on = 1'b1; sp.en = 1'b1;
        repeat (32) step();
        chk("prbs_strobes_seen", 64'(q_main.size()), 64'd0);
        sp.en = 1'b0; tim_on = 1'b0;
        step();
        chk_idle("en_fall_prbs");
        ramp_m = ramp_m + 16'd4;
        // Square over a full super-cycle, then a mid-frame switch to constant
        sp.mode = 2'd0;
        for (int j = 0; j <= 100; j++) begin
            e = (j / FL > 5) ? {NCH{16'h1234}} : ((j % FL) < FL / 2) ? '1 : '0;
            q_main.push_back(e);
        end
        c = 0; tim_on = 1'b1; sp.en = 1'b1;
        for (int i = 0; i < 13; i++) begin
            while (c < tab[i].c) step();
            chk($sformatf("table%0d", i),
                {sp.spclk, sp.sync, sp.frame_start, sp.smp_vd, sp.frm_cnt},
                {tab[i].spclk, tab[i].sync, tab[i].fs, tab[i].vd, 3'(tab[i].frm)});
        end
        while (c < 683) step();
        sp.mode = 2'd3; sp.const_val = 16'h1234;
        while (c < 803) step();
        sp.en = 1'b0; tim_on = 1'b0;
        step();
        chk_idle("en_fall_mid_frame");
        repeat (5) step();
        chk_idle("en_low_hold");
        chk("square_const_strobes_seen", 64'(q_main.size()), 64'd0);
        ramp_m = ramp_m + 16'd100;
        // Restart in ramp mode, then reset while enabled
        sp.mode = 2'd1;
        for (int j = 0; j < 3; j++) begin
            for (int k = 0; k < NCH; k++) e[k*W +: W] = ramp_m + 16'(j + k);
            q_main.push_back(e);
        end
        c = 0; tim_on = 1'b1; sp.en = 1'b1;
        step();
        chk("restart_frame0", {sp.frame_start, sp.sync, sp.frm_cnt}, {1'b1, 1'b1, 3'd0});
        repeat (19) step();
        rst = 1'b1; tim_on = 1'b0;
        step();
        chk_idle("rst_with_en");
        step();
        chk_idle("rst_hold");
        chk("ramp_strobes_before_rst", 64'(q_main.size()), 64'd0);
        for (int j = 0; j < 2; j++) begin
            for (int k = 0; k < NCH; k++) e[k*W +: W] = 16'(j + k);
            q_main.push_back(e);
        end
        rst = 1'b0; c = 0; tim_on = 1'b1;
        repeat (16) step();
        sp.en = 1'b0; tim_on = 1'b0;
        step();
        chk_idle("en_fall_after_rst");
        // Narrow instance: ramp wraps 0xFF -> 0x00 without a missing strobe
        sw.mode = 2'd1;
        for (int j = 0; j < 300; j++) begin
            for (int k = 0; k < NCH; k++) e8[k*W8 +: W8] = 8'(j + k);
            q_w.push_back(e8);
        end
        sw.en = 1'b1;
        repeat (1200) step();
        sw.en = 1'b0;
        repeat (3) step();
        chk("main_queue_left", 64'(q_main.size()), 64'd0);
        chk("w8_queue_left", 64'(q_w.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sync_pattern_gen.md
Name: sync_pattern_gen

Overview:
- Parametrised frame-sync / sample-clock / test-data generator for bench and loopback testing of the ADC acquisition path without a live front end.
- Produces the sample clock, frame sync and per-channel data levels that drive the board outputs. Also produces a parallel sample word with a valid strobe that can feed ad_cache in place of converter data.
- Adds multi-channel output, selectable data patterns, sync-blanking frames and clean enable/start behaviour.

Parameters:
DIV, 500, mclk cycles per sample period (100 MHz / 200 kHz); must be ≥4 and even
FRAME_LEN, 512, sample periods per frame
SYNC_LEN, 9, sample periods of sync high at frame start; must be <FRAME_LEN
NFRAME, 105, frames per super-cycle
NBLANK, 5, last NBLANK frames of each super-cycle carry no sync pulse; must be <NFRAME
NCHN, 4, number of data channels
DATA_NBIT, 16, sample word width per channel

Ports:
mclk  in  1  system clock
rst  in  1  synchronous active-high reset
en  in  1  generator enable
mode  in  2  pattern: 0 square, 1 ramp, 2 PRBS, 3 constant
const_val  in  DATA_NBIT  word used in mode 3
spclk  out  1  sample clock
sync  out  1  frame sync
data  out  NCHN  per-channel level = MSB of channel word
smp_word  out  NCHN*DATA_NBIT  channel words, channel 0 in LSBs
smp_vd  out  1  one-cycle strobe, smp_word updated
frame_start  out  1  one-cycle pulse at sample 0 of every frame
frm_cnt  out  $clog2(NFRAME)  current frame index

Behaviour:
- Clock and reset: one clock, mclk. Reset is synchronous and active-high on rst.
- Reset values: all outputs 0. div, sp_cnt and frm_cnt are 0. ramp is 0. LFSR is 16'hACE1. Active mode is 0.
- While en=0:
  - Counters held at 0 and all outputs driven 0.
  - ramp and LFSR keep their values; they are not reset by en.
- Rising en (first cycle en=1 after en=0 or rst):
  - Starts at div=0, sp_cnt=0, frm_cnt=0.
  - The mode input is latched into the active mode.
- Counters, advancing only when en=1:
  - div runs 0..DIV-1 and wraps.
  - When div==DIV-1, sp_cnt advances 0..FRAME_LEN-1 and wraps.
  - When sp_cnt wraps, frm_cnt advances 0..NFRAME-1 and wraps.
- Outputs are registered, one mclk after the counter state they decode:
  - spclk = (div < DIV/2): high for exactly DIV/2 cycles, then low for DIV/2 cycles.
  - sync = (sp_cnt < SYNC_LEN) && (frm_cnt < NFRAME-NBLANK).
  - frame_start = 1 for one cycle when div==0 and sp_cnt==0.
  - smp_vd = 1 for one cycle when div==0, in the same cycle that the new smp_word appears.
- Pattern update: ramp, LFSR and smp_word update once per sample, on div==DIV-1. Channel k word, widths truncated/zero-extended to DATA_NBIT, all arithmetic mod 2^DATA_NBIT:
  - Square: all ones if the next sp_cnt < FRAME_LEN/2, else all zeros. This gives exactly FRAME_LEN/2 high samples.
  - Ramp: ramp+k. ramp increments by 1 per sample and wraps at 2^DATA_NBIT.
  - PRBS: LFSR value rotated left by 4k bits. Polynomial x^16+x^14+x^13+x^11+1, Fibonacci form, shifts left with feedback into bit 0, one step per sample.
  - Constant: const_val for all channels.
- Mode changes: mode is re-latched only on sp_cnt wrap (frame boundary). A mid-frame change takes effect at sample 0 of the next frame.
- Reset mid-operation: rst overrides en in the same cycle; the next cycle shows reset values.
- Simultaneous events: frame wrap and super-cycle wrap on the same div==DIV-1 are both applied in one cycle with no gap sample.

Decomposition:
- Shared package/globals holds the mode encodings (PAT_SQUARE=0, PAT_RAMP=1, PAT_PRBS=2, PAT_CONST=3), LFSR_SEED=16'hACE1 and the default rate constants.
- One sub-module: sync_timebase, covering the div/sp_cnt/frm_cnt counters, en edge detect and the decoded strobes.
- Pattern logic stays in the parent.

Test Plan:
1. Defaults, mode 0, en=1 after rst: spclk has period 500 cycles and 250 cycles high; sync is high for 9×500 cycles, then low for 503×500; data[k] is high for 256 samples, then low for 256.
2. Run 105 frames: sync pulses in frames 0–99 and none in frames 100–104; frm_cnt wraps 104→0 together with frame_start; sync reappears in frame 0.
3. Mode 1, NCHN=4: successive smp_vd words are ch0 = 0,1,2,…; ch3 = 3,4,5,…; the ramp wraps 0xFFFF→0x0000 with no skipped strobe.
4. Mode 2: first four ch0 words after en match a reference LFSR seeded 0xACE1; ch1 equals ch0 rotated left by 4.
5. Change mode 0→3 at sample 200 with const_val=0x1234: square continues to sample 511; the word becomes 0x1234 at the next frame_start.
6. Deassert en mid-frame, then re-assert: outputs go to 0 one cycle after en falls; on restart, sample 0 of frame 0 follows with a sync pulse; asserting rst together with en=1 yields all outputs 0 on the next cycle.
